// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between fetch (priority) and the loader/debug port.
// Optional IMEM_ARB_LOCK_EN adds l_lock for exclusive loader ownership across multiple accesses.
module imem_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
`ifdef IMEM_ARB_LOCK_EN
   input  logic              l_lock,
`endif
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2
   } owner_t;

   owner_t             rd_owner, rd_owner_nxt;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic               locked;

   // rst_n is an active-high synchronous reset despite its name
   always_ff @(posedge clk) begin
      if (rst_n) begin
         wait_cnt <= '0;
         rd_owner <= OWN_NONE;
      end else begin
         wait_cnt <= wait_cnt_nxt;
         rd_owner <= rd_owner_nxt;
      end
   end

`ifdef IMEM_ARB_LOCK_EN
   logic locked_nxt;

   // Lock is taken on a granted locked access and dropped on any edge with l_lock low
   always_ff @(posedge clk) begin
      if (rst_n) locked <= 1'b0;
      else       locked <= locked_nxt;
   end

   always_comb begin
      locked_nxt = 1'b0;
      if (l_lock) locked_nxt = locked | l_gnt;
   end
`else
   assign locked = 1'b0;
`endif

   // Grants, memory mux and next-state
   always_comb begin
      f_gnt        = 1'b0;
      l_gnt        = 1'b0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      wait_cnt_nxt = '0;
      rd_owner_nxt = OWN_NONE;

      if (!rst_n) begin
         l_gnt = l_req & ((wait_cnt == WAIT_MAX) | ~f_req | locked);
         f_gnt = f_req & ~l_gnt & ~locked;
      end

      if (f_gnt) begin
         mem_en   = 1'b1;
         mem_addr = f_addr;
      end else if (l_gnt) begin
         mem_en    = 1'b1;
         mem_we    = l_we;
         mem_addr  = l_addr;
         mem_wdata = l_wdata;
      end

      if (l_req && !l_gnt)
         wait_cnt_nxt = (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + CNT_W'(1);

      if (f_gnt)              rd_owner_nxt = OWN_FETCH;
      else if (l_gnt && !l_we) rd_owner_nxt = OWN_LOAD;
   end

   assign f_rvalid = (rd_owner == OWN_FETCH) & ~rst_n;
   assign l_rvalid = (rd_owner == OWN_LOAD) & ~rst_n;
   assign f_rdata  = mem_rdata;
   assign l_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: behavioural memory, read-data scoreboard, per-cycle grant/mux checks.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req, l_req, l_we, l_lock;
   logic [31:0] f_addr, l_addr, l_wdata;
   logic        f_gnt, f_rvalid, l_gnt, l_rvalid;
   logic [31:0] f_rdata, l_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        is_fetch;
      logic [31:0] data;
   } rd_exp_t;

   rd_exp_t     exp_q[$];
   logic [31:0] mem_model [0:1023];
   logic [31:0] exp_mem   [0:1023];

   always #5 clk = ~clk;

   imem_arbiter dut (
      .clk(clk), .rst_n(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
`ifdef IMEM_ARB_LOCK_EN
      .l_lock(l_lock),
`endif
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Single-port synchronous memory, one-cycle read latency
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_model[mem_addr[11:2]] <= mem_wdata;
         else        mem_rdata <= mem_model[mem_addr[11:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: check outputs at the falling edge, then step past the next rising edge
   task automatic tick(input logic ef, input logic el);
      rd_exp_t e;
      logic    pend;
      @(negedge clk);
      pend = (exp_q.size() > 0);
      e    = '0;
      if (pend) e = exp_q.pop_front();
      chk("f_rvalid", 32'(f_rvalid), 32'(pend & e.is_fetch & ~rst));
      chk("l_rvalid", 32'(l_rvalid), 32'(pend & ~e.is_fetch & ~rst));
      if (pend && !rst) begin
         if (e.is_fetch) chk("f_rdata", f_rdata, e.data);
         else            chk("l_rdata", l_rdata, e.data);
      end
      chk("f_gnt", 32'(f_gnt), 32'(ef));
      chk("l_gnt", 32'(l_gnt), 32'(el));
      if (ef) begin
         chk("mem_en", 32'(mem_en), 32'd1);
         chk("mem_we", 32'(mem_we), 32'd0);
         chk("mem_addr", mem_addr, f_addr);
         exp_q.push_back({1'b1, exp_mem[f_addr[11:2]]});
      end else if (el) begin
         chk("mem_en", 32'(mem_en), 32'd1);
         chk("mem_we", 32'(mem_we), 32'(l_we));
         chk("mem_addr", mem_addr, l_addr);
         if (l_we) begin
            chk("mem_wdata", mem_wdata, l_wdata);
            exp_mem[l_addr[11:2]] = l_wdata;
         end else begin
            exp_q.push_back({1'b0, exp_mem[l_addr[11:2]]});
         end
      end else begin
         chk("mem_en_idle", 32'(mem_en), 32'd0);
         chk("mem_we_idle", 32'(mem_we), 32'd0);
         chk("mem_addr_idle", mem_addr, 32'd0);
         chk("mem_wdata_idle", mem_wdata, 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_model[i] = {16'hC0DE, 4'h0, 10'(i), 2'b00};
         exp_mem[i]   = {16'hC0DE, 4'h0, 10'(i), 2'b00};
      end
      rst = 1'b1; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
      f_addr = '0; l_addr = '0; l_wdata = '0;

      // Reset holds grants and memory enable low
      l_req = 1'b1; f_req = 1'b1;
      tick(1'b0, 1'b0);
      l_req = 1'b0; f_req = 1'b0;
      tick(1'b0, 1'b0);
      rst = 1'b0;
      tick(1'b0, 1'b0);
      chk("wait_cnt_reset", 32'(dut.wait_cnt), 32'd0);

      // Back-to-back uncontended fetch
      f_req = 1'b1; f_addr = 32'h0;
      tick(1'b1, 1'b0);
      f_addr = 32'h4;
      tick(1'b1, 1'b0);
      f_req = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      // Loader write starved by continuous fetch, granted after MAX_WAIT denials
      f_req = 1'b1; f_addr = 32'h10;
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h100; l_wdata = 32'hDEADBEEF;
      repeat (4) tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      l_req = 1'b0;
      tick(1'b1, 1'b0);
      f_req = 1'b0;
      tick(1'b0, 1'b0);

      // Loader read-back while fetch idle
      l_req = 1'b1; l_we = 1'b0; l_addr = 32'h100;
      tick(1'b0, 1'b1);
      l_req = 1'b0;
      tick(1'b0, 1'b0);
      chk("readback_const", exp_mem[32'h100 >> 2], 32'hDEADBEEF);

      // Reset in the data cycle of a granted fetch suppresses rvalid
      f_req = 1'b1; f_addr = 32'h8;
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h200; l_wdata = 32'h0BADF00D;
      tick(1'b1, 1'b0);
      rst = 1'b1;
      tick(1'b0, 1'b0);
      rst = 1'b0; f_req = 1'b0; l_req = 1'b0;
      tick(1'b0, 1'b0);
      chk("wait_cnt_after_rst", 32'(dut.wait_cnt), 32'd0);

      // Cancelled loader request restarts the starvation count
      f_req = 1'b1; f_addr = 32'hC;
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h104; l_wdata = 32'h12345678;
      repeat (2) tick(1'b1, 1'b0);
      l_req = 1'b0;
      tick(1'b1, 1'b0);
      l_req = 1'b1;
      repeat (4) tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      l_req = 1'b0;
      f_addr = 32'h104;
      tick(1'b1, 1'b0);
      f_req = 1'b0;
      tick(1'b0, 1'b0);

      // Loader read of the new word, then a fetch read of the first written word
      l_req = 1'b1; l_we = 1'b0; l_addr = 32'h104;
      tick(1'b0, 1'b1);
      l_req = 1'b0; f_req = 1'b1; f_addr = 32'h100;
      tick(1'b1, 1'b0);
      f_req = 1'b0;
      tick(1'b0, 1'b0);

`ifdef IMEM_ARB_LOCK_EN
      // Locked multi-word write keeps fetch stalled until the cycle after l_lock drops
      f_req = 1'b1; f_addr = 32'h20;
      l_lock = 1'b1; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h300; l_wdata = 32'hA0000001;
      repeat (4) tick(1'b1, 1'b0);
      tick(1'b0, 1'b1);
      l_req = 1'b0;
      tick(1'b0, 1'b0);
      l_req = 1'b1; l_addr = 32'h304; l_wdata = 32'hA0000002;
      tick(1'b0, 1'b1);
      l_req = 1'b0;
      tick(1'b0, 1'b0);
      l_req = 1'b1; l_addr = 32'h308; l_wdata = 32'hA0000003;
      tick(1'b0, 1'b1);
      l_req = 1'b0; l_lock = 1'b0;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      f_addr = 32'h304;
      tick(1'b1, 1'b0);
      f_req = 1'b0;
      tick(1'b0, 1'b0);
`endif

      tick(1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single-port synchronous instruction memory between the fetch path (PC-driven instruction reads) and a loader/debug port that writes program images and reads them back. Fetch has priority; a starvation counter guarantees the loader a slot within a bounded number of cycles. It sits between the `pc` and the instruction memory. A denied fetch request is the PC's stall signal.

## Interface
- `ADDR_W`, 32: address width, both requesters and memory.
- `DATA_W`, 32: data width.
- `MAX_WAIT`, 4: consecutive denied loader cycles before the loader overrides fetch; legal range 1..15.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-high reset.
- `f_req`  in  1  fetch read request; `f_addr` stable while asserted.
- `f_addr`  in  ADDR_W  fetch byte address.
- `f_gnt`  out  1  fetch granted this cycle (combinational).
- `f_rvalid`  out  1  fetch read data valid (registered).
- `f_rdata`  out  DATA_W  fetch read data.
- `l_req`  in  1  loader request.
- `l_we`  in  1  loader write (1) / read (0).
- `l_addr`  in  ADDR_W  loader address.
- `l_wdata`  in  DATA_W  loader write data.
- `l_gnt`  out  1  loader granted this cycle (combinational).
- `l_rvalid`  out  1  loader read data valid (registered); never set for writes.
- `l_rdata`  out  DATA_W  loader read data.
- `l_lock`  in  1  hold exclusive ownership; present only with `IMEM_ARB_LOCK_EN`.
- `mem_en`, `mem_we`  out  1  memory enable / write enable.
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W; `mem_rdata`  in  DATA_W (valid the cycle after a read enable).

## Operation
- State: `wait_cnt` (4 bits), `rd_owner` (2 bits: none/fetch/loader), `locked` (macro only).
- Grant, per cycle, with reset low: `l_gnt = l_req & (wait_cnt == MAX_WAIT | !f_req | locked)`; `f_gnt = f_req & !l_gnt & !locked`. At most one grant per cycle.
- Memory mux: with `f_gnt`, `mem_en=1`, `mem_we=0`, `mem_addr=f_addr`. With `l_gnt`, `mem_en=1`, `mem_we=l_we`, `mem_addr=l_addr`, `mem_wdata=l_wdata`. With no grant, `mem_en=0`, `mem_we=0`, and address/data are 0.
- `wait_cnt`: increments when `l_req & !l_gnt`. Clears to 0 when `l_gnt` or `!l_req`. Saturates at `MAX_WAIT`.
- `rd_owner` is registered each cycle: fetch if `f_gnt`; loader if `l_gnt & !l_we`; otherwise none.
- `f_rvalid = (rd_owner==fetch)`, `l_rvalid = (rd_owner==loader)`. `f_rdata = l_rdata = mem_rdata` (unqualified; consumers qualify with rvalid).
- Requesters hold `req` and payload until granted. Deasserting `req` before grant is legal and cancels the request.

## Timing
- Reset (cycle with `rst_n=1`): `f_gnt`, `l_gnt`, `mem_en`, `mem_we` forced 0. On the next edge, `wait_cnt=0`, `rd_owner=none`, `locked=0`. Hence `f_rvalid=l_rvalid=0` the cycle after reset.
- Reset mid-operation: a read granted in the cycle before reset asserts produces no rvalid if reset is high in the data cycle. The rvalid outputs are forced 0 while reset is high.
- Grant latency: 0 cycles (same cycle as `req`) when uncontended.
- Read latency: rvalid exactly 1 cycle after grant. Writes complete at the grant edge.
- Back-to-back fetch: one grant per cycle, throughput 1 read/cycle.
- Worst-case loader wait under continuous fetch: granted in the cycle after `MAX_WAIT` denied cycles (cycle index `MAX_WAIT` counting from request).
- Simultaneous `f_req`/`l_req` with `wait_cnt<MAX_WAIT`: fetch wins. With `wait_cnt==MAX_WAIT`: loader wins and fetch stalls exactly that cycle.

## Configuration
- `IMEM_ARB_LOCK_EN` defined:
  - `l_lock` port exists.
  - `locked` sets on an edge with `l_gnt & l_lock`, and clears on any edge with `l_lock=0`.
  - While `locked`, `f_gnt=0` even when `l_req=0`. This gives the loader atomic multi-word image writes.
- Not defined: no `l_lock` port, `locked` is constant 0, and pure priority plus starvation counter applies.

## Test plan
- Reset, then `f_req=1`, `f_addr=0x0`, and `0x4` the next cycle, with `l_req=0` → `f_gnt=1` both cycles. `f_rvalid=1` the following cycles with `mem_rdata` words. `l_rvalid=0` throughout.
- Continuous `f_req`, `l_req=1`, `l_we=1`, `l_addr=0x100`, `l_wdata=0xDEADBEEF`, `MAX_WAIT=4` → `l_gnt` low for 4 cycles, high in the 5th with `mem_we=1`. `f_gnt=0` that cycle only; no `l_rvalid`.
- Loader read of `0x100` while fetch idle → `l_gnt` same cycle, `l_rvalid=1` next cycle with `l_rdata=0xDEADBEEF`.
- Fetch granted at `0x8`, `rst_n=1` the next cycle → `f_rvalid=0` and `mem_en=0` during reset; `wait_cnt=0` after.
- `l_req` high for 2 denied cycles, then dropped, then re-raised under continuous fetch → `wait_cnt` restarts from 0, and the grant takes a full 4 denied cycles again.
- With `IMEM_ARB_LOCK_EN`: `l_lock=1` with 3 writes spaced by idle cycles and `f_req=1` constant → `f_gnt=0` until the cycle after `l_lock` drops, then `f_gnt=1`.
